// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: groups the execution/pc_reg side signals of the pipeline
// sequencer into one bundle.
//   slave  modport : used by pipe_ctrl (consumes *_i, drives *_o)
//   master modport : used by the environment (drives *_i, observes *_o)
// Signals:
//   jump_en_i / jump_addr_i : taken branch/JAL and its target from EX
//   pc_i                    : current PC from pc_reg
//   halt_req_i              : debug halt request (level)
//   jump_en_o / jump_addr_o : redirect strobe and target to pc_reg
//   hold_pc_o               : freeze the PC
//   flush_o                 : load a bubble into IF/ID and ID/EX
//   halt_ack_o              : core halted, pipeline empty
//   halt_pc_o               : resume address
//   state_o                 : sequencer state (0=RUN, 1=DRAIN, 2=HALTED)
interface pipe_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [31:0] pc_i;
    logic        halt_req_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o;
    logic        flush_o;
    logic        halt_ack_o;
    logic [31:0] halt_pc_o;
    logic [1:0]  state_o;

    modport slave (
        input  jump_en_i, jump_addr_i, pc_i, halt_req_i,
        output jump_en_o, jump_addr_o, hold_pc_o, flush_o,
               halt_ack_o, halt_pc_o, state_o
    );

    modport master (
        output jump_en_i, jump_addr_i, pc_i, halt_req_i,
        input  jump_en_o, jump_addr_o, hold_pc_o, flush_o,
               halt_ack_o, halt_pc_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 3-stage core (IF, ID, EX).
// Redirects the PC and flushes IF/ID and ID/EX on a taken branch/JAL, and
// runs the debug halt handshake (drain, freeze fetch, report resume PC).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pipe_ctrl_if.slave (see interface file for signal list)
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | normal execution; jumps redirect and flush
// DRAIN  | PC held, bubbles injected, waiting for in-flight work to retire
// HALTED | pipeline empty, halt acknowledged, halt_pc_o holds resume PC
// (3)    | unused encoding, returns to RUN on the next edge
module pipe_ctrl #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    // A drain of zero cycles would skip the retire window, so clamp to one.
    localparam int DC_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int CNT_W  = $clog2(DC_EFF + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [31:0]      r_halt_pc;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_drain_cnt_nxt;
    logic [31:0]      w_halt_pc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_halt_pc   <= RESET_ADDR;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_halt_pc   <= w_halt_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_halt_pc_nxt   = r_halt_pc;
        case (r_state)
            ST_RUN: begin
                if (bus.halt_req_i) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = CNT_W'(DC_EFF - 1);
                end
            end
            ST_DRAIN: begin
                if (!bus.halt_req_i) begin
                    w_state_nxt = ST_RUN;
                end else if (r_drain_cnt == '0) begin
                    w_state_nxt   = ST_HALTED;
                    // A branch resolving in the last drain cycle decides
                    // where execution must resume.
                    w_halt_pc_nxt = bus.jump_en_i ? bus.jump_addr_i : bus.pc_i;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 1'b1;
                end
            end
            ST_HALTED: begin
                if (!bus.halt_req_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        bus.jump_en_o  = 1'b0;
        bus.hold_pc_o  = 1'b0;
        bus.flush_o    = 1'b1;
        bus.halt_ack_o = 1'b0;
        case (r_state)
            ST_RUN: begin
                bus.jump_en_o = bus.jump_en_i;
                bus.flush_o   = bus.jump_en_i;
            end
            ST_DRAIN: begin
                // pc_reg gives the redirect priority over the hold.
                bus.jump_en_o = bus.jump_en_i;
                bus.hold_pc_o = 1'b1;
            end
            ST_HALTED: begin
                bus.hold_pc_o  = 1'b1;
                bus.halt_ack_o = 1'b1;
            end
            default: begin
                bus.jump_en_o = 1'b0;
            end
        endcase
        if (rst) begin
            bus.jump_en_o  = 1'b0;
            bus.hold_pc_o  = 1'b0;
            bus.flush_o    = 1'b1;
            bus.halt_ack_o = 1'b0;
        end
    end

    assign bus.jump_addr_o = bus.jump_addr_i;
    assign bus.halt_pc_o   = r_halt_pc;
    assign bus.state_o     = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    typedef struct {
        logic        rst;
        logic        jen;
        logic [31:0] jaddr;
        logic [31:0] pc;
        logic        hreq;
        logic        e_jen;
        logic [31:0] e_jaddr;
        logic        e_hold;
        logic        e_flush;
        logic        e_ack;
        logic [31:0] e_hpc;
        logic [1:0]  e_state;
    } vec_t;

    typedef struct {
        int          idx;
        logic        e_jen;
        logic [31:0] e_jaddr;
        logic        e_hold;
        logic        e_flush;
        logic        e_ack;
        logic [31:0] e_hpc;
        logic [1:0]  e_state;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .RESET_ADDR   (32'h0000_0000),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    task automatic add(input logic r, input logic j, input logic [31:0] ja,
                       input logic [31:0] p, input logic h,
                       input logic ej, input logic eh, input logic ef,
                       input logic ea, input logic [31:0] ehpc,
                       input logic [1:0] es);
        vec_t v;
        v.rst = r; v.jen = j; v.jaddr = ja; v.pc = p; v.hreq = h;
        v.e_jen = ej; v.e_jaddr = ja; v.e_hold = eh; v.e_flush = ef;
        v.e_ack = ea; v.e_hpc = ehpc; v.e_state = es;
        vecs.push_back(v);
    endtask

    task automatic chk1(input string name, input int idx, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL v%0d %s: got %b want %b", idx, name, a, e);
        end
    endtask

    task automatic chk32(input string name, input int idx, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL v%0d %s: got %h want %h", idx, name, a, e);
        end
    endtask

    // Monitor: the DUT outputs are valid every cycle once the vector is applied;
    // compare on the falling edge against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk1 ("jump_en_o",   e.idx, bus.jump_en_o,  e.e_jen);
                chk32("jump_addr_o", e.idx, bus.jump_addr_o, e.e_jaddr);
                chk1 ("hold_pc_o",   e.idx, bus.hold_pc_o,  e.e_hold);
                chk1 ("flush_o",     e.idx, bus.flush_o,    e.e_flush);
                chk1 ("halt_ack_o",  e.idx, bus.halt_ack_o, e.e_ack);
                chk32("halt_pc_o",   e.idx, bus.halt_pc_o,  e.e_hpc);
                chk32("state_o",     e.idx, {30'd0, bus.state_o}, {30'd0, e.e_state});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        //   rst jen jaddr        pc           hreq  ejen hold flush ack hpc          st
        // reset held two cycles with halt requested
        add(1, 0, 32'h0,  32'h0,  1,    0, 0, 1, 0, 32'h0,  2'd0);
        add(1, 0, 32'h0,  32'h0,  1,    0, 0, 1, 0, 32'h0,  2'd0);
        // release: RUN sees halt request, enters DRAIN, then aborted
        add(0, 0, 32'h0,  32'h0,  1,    0, 0, 0, 0, 32'h0,  2'd0);
        add(0, 0, 32'h0,  32'h0,  0,    0, 1, 1, 0, 32'h0,  2'd1);
        add(0, 0, 32'h0,  32'h0,  0,    0, 0, 0, 0, 32'h0,  2'd0);
        // jump in RUN for one cycle
        add(0, 1, 32'h40, 32'h8,  0,    1, 0, 1, 0, 32'h0,  2'd0);
        add(0, 0, 32'h0,  32'hC,  0,    0, 0, 0, 0, 32'h0,  2'd0);
        // halt handshake at pc 0x1C
        add(0, 0, 32'h0,  32'h1C, 1,    0, 0, 0, 0, 32'h0,  2'd0);
        add(0, 0, 32'h0,  32'h1C, 1,    0, 1, 1, 0, 32'h0,  2'd1);
        add(0, 0, 32'h0,  32'h1C, 1,    0, 1, 1, 0, 32'h0,  2'd1);
        add(0, 0, 32'h0,  32'h1C, 1,    0, 1, 1, 1, 32'h1C, 2'd2);
        // jump ignored while halted
        add(0, 1, 32'h99, 32'h1C, 1,    0, 1, 1, 1, 32'h1C, 2'd2);
        add(0, 0, 32'h0,  32'h1C, 0,    0, 1, 1, 1, 32'h1C, 2'd2);
        add(0, 0, 32'h0,  32'h1C, 0,    0, 0, 0, 0, 32'h1C, 2'd0);
        // jump in final DRAIN cycle sets resume PC
        add(0, 0, 32'h0,  32'h20, 1,    0, 0, 0, 0, 32'h1C, 2'd0);
        add(0, 0, 32'h0,  32'h20, 1,    0, 1, 1, 0, 32'h1C, 2'd1);
        add(0, 1, 32'h80, 32'h20, 1,    1, 1, 1, 0, 32'h1C, 2'd1);
        add(0, 0, 32'h0,  32'h20, 1,    0, 1, 1, 1, 32'h80, 2'd2);
        // reset while halted
        add(1, 0, 32'h0,  32'h20, 1,    0, 0, 1, 0, 32'h80, 2'd2);
        add(0, 0, 32'h0,  32'h24, 0,    0, 0, 0, 0, 32'h0,  2'd0);
        // halt request together with a jump, then one-cycle abort
        add(0, 1, 32'h44, 32'h24, 1,    1, 0, 1, 0, 32'h0,  2'd0);
        add(0, 0, 32'h0,  32'h44, 0,    0, 1, 1, 0, 32'h0,  2'd1);
        add(0, 0, 32'h0,  32'h44, 0,    0, 0, 0, 0, 32'h0,  2'd0);
        // jump in a non-final DRAIN cycle still redirects
        add(0, 0, 32'h0,  32'h48, 1,    0, 0, 0, 0, 32'h0,  2'd0);
        add(0, 1, 32'hA0, 32'h48, 1,    1, 1, 1, 0, 32'h0,  2'd1);
        add(0, 0, 32'h0,  32'hA0, 1,    0, 1, 1, 0, 32'h0,  2'd1);
        add(0, 0, 32'h0,  32'hA0, 1,    0, 1, 1, 1, 32'hA0, 2'd2);

        rst = 1'b1;
        bus.jump_en_i   = 1'b0;
        bus.jump_addr_i = 32'h0;
        bus.pc_i        = 32'h0;
        bus.halt_req_i  = 1'b1;
        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            rst             = vecs[i].rst;
            bus.jump_en_i   = vecs[i].jen;
            bus.jump_addr_i = vecs[i].jaddr;
            bus.pc_i        = vecs[i].pc;
            bus.halt_req_i  = vecs[i].hreq;
            e.idx     = i;
            e.e_jen   = vecs[i].e_jen;
            e.e_jaddr = vecs[i].e_jaddr;
            e.e_hold  = vecs[i].e_hold;
            e.e_flush = vecs[i].e_flush;
            e.e_ack   = vecs[i].e_ack;
            e.e_hpc   = vecs[i].e_hpc;
            e.e_state = vecs[i].e_state;
            sb.push_back(e);
            @(posedge clk);
        end
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
